// File: rtl/trigger_clk_ps_ctrl.sv
// trigger_clk_ps_ctrl
//
// Sequences the trigger-clock MMCM dynamic phase-shift port. A register-level
// request for N steps in one direction becomes N one-cycle psen pulses. Each
// pulse waits for psdone, and MMCM lock is re-checked before every step. The
// block tracks the accumulated signed phase offset (saturating) and reports
// busy / done / error status. Runs entirely on usb_clk (psclk = usb_clk).
//
// Optional feature macro: TRIG_PS_TIMEOUT_EN
//   When defined, a wait of pTIMEOUT cycles in WAIT_LOCK or WAIT_DONE ends the
//   sequence and sets the sticky O_error flag.
//   When undefined, both wait states wait forever and O_error is tied to 0.
//
// Ports:
//   usb_clk        sole clock
//   reset          asynchronous active-high reset
//   I_ps_request   one-cycle start pulse (only honoured when idle)
//   I_ps_steps     step count, sampled with the request
//   I_ps_dir       1 = increment, 0 = decrement, sampled with the request
//   I_abort        stop after the in-flight step
//   I_phase_clear  zero O_phase (wins over a same-cycle step update)
//   I_locked       MMCM locked (asynchronous, double-flopped here)
//   I_psdone       MMCM psdone
//   O_psen         MMCM psen, one cycle per step
//   O_psincdec     MMCM psincdec, held for the whole sequence
//   O_busy         sequence in progress
//   O_done         one-cycle completion pulse
//   O_error        sticky timeout flag, cleared by the next request
//   O_remaining    steps still to issue
//   O_phase        signed accumulated phase offset
module trigger_clk_ps_ctrl #(
  parameter int unsigned pSTEP_WIDTH  = 16,
  parameter int unsigned pPHASE_WIDTH = 16,
  parameter int unsigned pTIMEOUT     = 1023
) (
  input  logic                    usb_clk,
  input  logic                    reset,
  input  logic                    I_ps_request,
  input  logic [pSTEP_WIDTH-1:0]  I_ps_steps,
  input  logic                    I_ps_dir,
  input  logic                    I_abort,
  input  logic                    I_phase_clear,
  input  logic                    I_locked,
  input  logic                    I_psdone,
  output logic                    O_psen,
  output logic                    O_psincdec,
  output logic                    O_busy,
  output logic                    O_done,
  output logic                    O_error,
  output logic [pSTEP_WIDTH-1:0]  O_remaining,
  output logic [pPHASE_WIDTH-1:0] O_phase
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLock,
    StPulse,
    StWaitDone,
    StFinish
  } state_e;

  localparam logic [pPHASE_WIDTH-1:0] PhaseMax = {1'b0, {(pPHASE_WIDTH-1){1'b1}}};
  localparam logic [pPHASE_WIDTH-1:0] PhaseMin = {1'b1, {(pPHASE_WIDTH-1){1'b0}}};

  state_e                  r_state;
  logic                    r_lock_meta;
  logic                    r_lock_sync;
  logic                    r_abort_pend;
  logic                    r_psen;
  logic                    r_psincdec;
  logic                    r_busy;
  logic                    r_done;
  logic [pSTEP_WIDTH-1:0]  r_remaining;
  logic [pPHASE_WIDTH-1:0] r_phase;

  logic                    w_abort;
  logic [pSTEP_WIDTH-1:0]  w_rem_dec;
  logic                    w_last;
  logic [pPHASE_WIDTH-1:0] w_phase_step;

`ifdef TRIG_PS_TIMEOUT_EN
  localparam int unsigned TmoW = (pTIMEOUT > 2) ? $clog2(pTIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(pTIMEOUT - 1);

  logic [TmoW-1:0] r_tmo;
  logic            r_error;
`endif

  // A same-cycle abort pulse counts as pending so WAIT_LOCK can leave at once.
  assign w_abort   = r_abort_pend | I_abort;
  assign w_rem_dec = r_remaining - 1'b1;
  assign w_last    = (w_rem_dec == '0);

  // Saturating +/-1 step of the phase offset in the latched direction.
  always_comb begin
    w_phase_step = r_phase;
    if (r_psincdec) begin
      if (r_phase != PhaseMax) w_phase_step = r_phase + 1'b1;
    end else begin
      if (r_phase != PhaseMin) w_phase_step = r_phase - 1'b1;
    end
  end

  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_lock_meta  <= 1'b0;
      r_lock_sync  <= 1'b0;
      r_abort_pend <= 1'b0;
      r_psen       <= 1'b0;
      r_psincdec   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_remaining  <= '0;
      r_phase      <= '0;
`ifdef TRIG_PS_TIMEOUT_EN
      r_tmo        <= '0;
      r_error      <= 1'b0;
`endif
    end else begin
      r_lock_meta <= I_locked;
      r_lock_sync <= r_lock_meta;
      r_psen      <= 1'b0;
      r_done      <= 1'b0;
`ifdef TRIG_PS_TIMEOUT_EN
      // Counter restarts on every state change; wait states increment it.
      r_tmo       <= '0;
`endif

      unique case (r_state)
        StIdle: begin
          r_abort_pend <= 1'b0;
          r_busy       <= 1'b0;
          if (I_ps_request) begin
            r_remaining <= I_ps_steps;
            r_psincdec  <= I_ps_dir;
            r_busy      <= 1'b1;
            r_state     <= StWaitLock;
`ifdef TRIG_PS_TIMEOUT_EN
            r_error     <= 1'b0;
`endif
          end
        end

        StWaitLock: begin
          if (I_abort) r_abort_pend <= 1'b1;
          if (w_abort) begin
            r_state <= StFinish;
          end else if (r_lock_sync) begin
            if (r_remaining == '0) begin
              r_state <= StFinish;
            end else begin
              r_state <= StPulse;
              r_psen  <= 1'b1;
            end
          end else begin
`ifdef TRIG_PS_TIMEOUT_EN
            if (r_tmo == TmoLast) begin
              r_error <= 1'b1;
              r_state <= StFinish;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
`endif
          end
        end

        StPulse: begin
          if (I_abort) r_abort_pend <= 1'b1;
          r_state <= StWaitDone;
        end

        StWaitDone: begin
          if (I_abort) r_abort_pend <= 1'b1;
          if (I_psdone) begin
            r_remaining <= w_rem_dec;
            r_phase     <= w_phase_step;
            r_state     <= (w_last || w_abort) ? StFinish : StWaitLock;
          end else begin
`ifdef TRIG_PS_TIMEOUT_EN
            if (r_tmo == TmoLast) begin
              r_error <= 1'b1;
              r_state <= StFinish;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
`endif
          end
        end

        StFinish: begin
          if (I_abort) r_abort_pend <= 1'b1;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end

        default: r_state <= StIdle;
      endcase

      // Placed after the case so a clear overrides a same-cycle step update.
      if (I_phase_clear) r_phase <= '0;
    end
  end

  assign O_psen      = r_psen;
  assign O_psincdec  = r_psincdec;
  assign O_busy      = r_busy;
  assign O_done      = r_done;
  assign O_remaining = r_remaining;
  assign O_phase     = r_phase;

`ifdef TRIG_PS_TIMEOUT_EN
  assign O_error = r_error;
`else
  // Timeout depth only matters when the timeout feature is built in.
  logic w_unused_tmo;
  assign w_unused_tmo = |pTIMEOUT;
  assign O_error      = 1'b0;
`endif

endmodule
